// File: rtl/regfile_dual_wb_if.sv
// Writeback-to-regfile interface: the dual-slot commit bus, the four GPR read
// address/data pairs, the HI/LO read data and the same-address conflict flag.
//   wb_to_rf_bus : two commit slots, slot1 in the low half, slot2 in the high half
//   raddr1..4    : GPR read addresses (1,2 = slot1 rs/rt, 3,4 = slot2 rs/rt)
//   rdata1..4    : GPR read data with write-through bypass
//   hi_rdata     : HI value with bypass
//   lo_rdata     : LO value with bypass
//   wr_conflict  : previous cycle wrote the same nonzero GPR from both slots
// The master modport belongs to the writeback/decode side; the slave modport
// belongs to the register file.
interface regfile_dual_wb_if #(
  parameter int DATA_W = 32,
  parameter int AW     = 5
);
  localparam int SLOT_W = 3 * DATA_W + AW + 3;

  logic [2*SLOT_W-1:0] wb_to_rf_bus;
  logic [AW-1:0]       raddr1;
  logic [AW-1:0]       raddr2;
  logic [AW-1:0]       raddr3;
  logic [AW-1:0]       raddr4;
  logic [DATA_W-1:0]   rdata1;
  logic [DATA_W-1:0]   rdata2;
  logic [DATA_W-1:0]   rdata3;
  logic [DATA_W-1:0]   rdata4;
  logic [DATA_W-1:0]   hi_rdata;
  logic [DATA_W-1:0]   lo_rdata;
  logic                wr_conflict;

  modport master (
    output wb_to_rf_bus, raddr1, raddr2, raddr3, raddr4,
    input  rdata1, rdata2, rdata3, rdata4, hi_rdata, lo_rdata, wr_conflict
  );

  modport slave (
    input  wb_to_rf_bus, raddr1, raddr2, raddr3, raddr4,
    output rdata1, rdata2, rdata3, rdata4, hi_rdata, lo_rdata, wr_conflict
  );
endinterface

// File: rtl/regfile_dual_wb.sv
// Dual-issue architectural register file: 32 GPRs plus HI and LO.
// Both writeback slots commit every cycle; slot2 is the younger instruction
// and wins any same-target collision. Reads are combinational with
// same-cycle write-through bypass, slot2 first, then slot1, then storage.
//   clk    : rising-edge clock
//   resetn : asynchronous active-low reset, clears all state
//   rf     : regfile_dual_wb_if slave (commit bus, read ports, conflict flag)
// Per-slot bus layout, MSB first:
//   {hi_we, lo_we, hi_wdata, lo_wdata, we, waddr, wdata}
module regfile_dual_wb #(
  parameter int DATA_W  = 32,
  parameter int REG_NUM = 32,
  parameter int AW      = 5
) (
  input  logic             clk,
  input  logic             resetn,
  regfile_dual_wb_if.slave rf
);

  localparam int SLOT_W = 3 * DATA_W + AW + 3;

  // Slot field extraction
  logic [SLOT_W-1:0] s1_bus_s, s2_bus_s;
  logic              s1_we_s, s2_we_s;
  logic [AW-1:0]     s1_waddr_s, s2_waddr_s;
  logic [DATA_W-1:0] s1_wdata_s, s2_wdata_s;
  logic              s1_hi_we_s, s2_hi_we_s, s1_lo_we_s, s2_lo_we_s;
  logic [DATA_W-1:0] s1_hi_s, s2_hi_s, s1_lo_s, s2_lo_s;

  assign s1_bus_s   = rf.wb_to_rf_bus[SLOT_W-1:0];
  assign s2_bus_s   = rf.wb_to_rf_bus[2*SLOT_W-1:SLOT_W];

  assign s1_wdata_s = s1_bus_s[DATA_W-1:0];
  assign s1_waddr_s = s1_bus_s[DATA_W +: AW];
  assign s1_we_s    = s1_bus_s[DATA_W+AW];
  assign s1_lo_s    = s1_bus_s[DATA_W+AW+1 +: DATA_W];
  assign s1_hi_s    = s1_bus_s[2*DATA_W+AW+1 +: DATA_W];
  assign s1_lo_we_s = s1_bus_s[3*DATA_W+AW+1];
  assign s1_hi_we_s = s1_bus_s[3*DATA_W+AW+2];

  assign s2_wdata_s = s2_bus_s[DATA_W-1:0];
  assign s2_waddr_s = s2_bus_s[DATA_W +: AW];
  assign s2_we_s    = s2_bus_s[DATA_W+AW];
  assign s2_lo_s    = s2_bus_s[DATA_W+AW+1 +: DATA_W];
  assign s2_hi_s    = s2_bus_s[2*DATA_W+AW+1 +: DATA_W];
  assign s2_lo_we_s = s2_bus_s[3*DATA_W+AW+1];
  assign s2_hi_we_s = s2_bus_s[3*DATA_W+AW+2];

  // Architectural state
  logic [DATA_W-1:0] regs_r [REG_NUM];
  logic [DATA_W-1:0] hi_r, lo_r;
  logic              wr_conflict_r;

  // GPR, HI/LO commit and conflict flag; slot2 is checked first so it wins.
  // Entry 0 is cleared on reset and never written, so it stays zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
      hi_r          <= {DATA_W{1'b0}};
      lo_r          <= {DATA_W{1'b0}};
      wr_conflict_r <= 1'b0;
    end else begin
      for (int i = 1; i < REG_NUM; i++) begin
        if (s2_we_s && (s2_waddr_s == AW'(i))) begin
          regs_r[i] <= s2_wdata_s;
        end else if (s1_we_s && (s1_waddr_s == AW'(i))) begin
          regs_r[i] <= s1_wdata_s;
        end else begin
          regs_r[i] <= regs_r[i];
        end
      end

      if (s2_hi_we_s) begin
        hi_r <= s2_hi_s;
      end else if (s1_hi_we_s) begin
        hi_r <= s1_hi_s;
      end else begin
        hi_r <= hi_r;
      end

      if (s2_lo_we_s) begin
        lo_r <= s2_lo_s;
      end else if (s1_lo_we_s) begin
        lo_r <= s1_lo_s;
      end else begin
        lo_r <= lo_r;
      end

      // A discarded write to register 0 is not a conflict.
      wr_conflict_r <= s1_we_s && s2_we_s && (s1_waddr_s == s2_waddr_s)
                       && (s1_waddr_s != {AW{1'b0}});
    end
  end

  assign rf.wr_conflict = wr_conflict_r;

  // GPR read ports gathered into arrays so one loop serves all four
  logic [AW-1:0]     ra_s [4];
  logic [DATA_W-1:0] rd_s [4];

  assign ra_s[0] = rf.raddr1;
  assign ra_s[1] = rf.raddr2;
  assign ra_s[2] = rf.raddr3;
  assign ra_s[3] = rf.raddr4;

  // GPR read with zero register and slot2-then-slot1 bypass
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      rd_s[k] = {DATA_W{1'b0}};
      if (ra_s[k] == {AW{1'b0}}) begin
        rd_s[k] = {DATA_W{1'b0}};
      end else if (s2_we_s && (s2_waddr_s == ra_s[k])) begin
        rd_s[k] = s2_wdata_s;
      end else if (s1_we_s && (s1_waddr_s == ra_s[k])) begin
        rd_s[k] = s1_wdata_s;
      end else begin
        rd_s[k] = regs_r[ra_s[k]];
      end
    end
  end

  assign rf.rdata1 = rd_s[0];
  assign rf.rdata2 = rd_s[1];
  assign rf.rdata3 = rd_s[2];
  assign rf.rdata4 = rd_s[3];

  // HI read with bypass
  always_comb begin
    rf.hi_rdata = hi_r;
    if (s2_hi_we_s) begin
      rf.hi_rdata = s2_hi_s;
    end else if (s1_hi_we_s) begin
      rf.hi_rdata = s1_hi_s;
    end else begin
      rf.hi_rdata = hi_r;
    end
  end

  // LO read with bypass
  always_comb begin
    rf.lo_rdata = lo_r;
    if (s2_lo_we_s) begin
      rf.lo_rdata = s2_lo_s;
    end else if (s1_lo_we_s) begin
      rf.lo_rdata = s1_lo_s;
    end else begin
      rf.lo_rdata = lo_r;
    end
  end

endmodule

// File: tb/tb_regfile_dual_wb.sv
// Directed bench for regfile_dual_wb: a table of per-cycle bus/read vectors
// with hand-computed expected read data, plus hand sequences for reset.
module tb_regfile_dual_wb;

  logic clk;
  logic resetn;
  int   n_applied;
  int   n_miscompares;

  regfile_dual_wb_if #(.DATA_W(32), .AW(5)) rf_if ();

  regfile_dual_wb #(.DATA_W(32), .REG_NUM(32), .AW(5)) dut (
    .clk    (clk),
    .resetn (resetn),
    .rf     (rf_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [103:0] s1;
    logic [103:0] s2;
    logic [4:0]   ra1, ra2, ra3, ra4;
    logic [31:0]  e1, e2, e3, e4;
    logic [31:0]  ehi, elo;
    logic         econf;
  } vec_t;

  vec_t vecs[$];

  localparam logic [103:0] IDLE = 104'd0;

  function automatic logic [103:0] slot(input logic hwe, input logic lwe,
                                        input logic [31:0] hi, input logic [31:0] lo,
                                        input logic we, input logic [4:0] wa,
                                        input logic [31:0] wd);
    return {hwe, lwe, hi, lo, we, wa, wd};
  endfunction

  function automatic logic [103:0] gw(input logic [4:0] wa, input logic [31:0] wd);
    return slot(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, wa, wd);
  endfunction

  task automatic add(input string name, input logic [103:0] s1, input logic [103:0] s2,
                     input logic [4:0] a1, input logic [4:0] a2,
                     input logic [4:0] a3, input logic [4:0] a4,
                     input logic [31:0] e1, input logic [31:0] e2,
                     input logic [31:0] e3, input logic [31:0] e4,
                     input logic [31:0] ehi, input logic [31:0] elo, input logic ec);
    vec_t v;
    v.name = name; v.s1 = s1; v.s2 = s2;
    v.ra1 = a1; v.ra2 = a2; v.ra3 = a3; v.ra4 = a4;
    v.e1 = e1; v.e2 = e2; v.e3 = e3; v.e4 = e4;
    v.ehi = ehi; v.elo = elo; v.econf = ec;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [103:0] s1, input logic [103:0] s2,
                       input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] a3, input logic [4:0] a4);
    rf_if.wb_to_rf_bus = {s2, s1};
    rf_if.raddr1 = a1; rf_if.raddr2 = a2; rf_if.raddr3 = a3; rf_if.raddr4 = a4;
  endtask

  initial begin
    n_applied     = 0;
    n_miscompares = 0;
    resetn        = 1'b0;
    drive(IDLE, IDLE, 5'd0, 5'd0, 5'd0, 5'd0);

    // Reset with random bus traffic, including a forced same-address pair
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      rf_if.wb_to_rf_bus = {$urandom(), $urandom(), $urandom(), $urandom()};
      rf_if.wb_to_rf_bus[37:32]   = 6'b1_00011;
      rf_if.wb_to_rf_bus[141:136] = 6'b1_00011;
    end
    @(negedge clk);
    drive(IDLE, IDLE, 5'd1, 5'd3, 5'd17, 5'd31);
    resetn = 1'b1;
    #1;
    chk("reset.rdata1", rf_if.rdata1, 32'd0);
    chk("reset.rdata2", rf_if.rdata2, 32'd0);
    chk("reset.rdata3", rf_if.rdata3, 32'd0);
    chk("reset.rdata4", rf_if.rdata4, 32'd0);
    chk("reset.hi", rf_if.hi_rdata, 32'd0);
    chk("reset.lo", rf_if.lo_rdata, 32'd0);
    chk("reset.wr_conflict", {31'd0, rf_if.wr_conflict}, 32'd0);

    // name, slot1, slot2, raddr1..4, rdata1..4, hi, lo, wr_conflict (value before the edge)
    add("wr5",       gw(5'd5, 32'hDEADBEEF), IDLE, 5'd5, 5'd0, 5'd5, 5'd6,
        32'hDEADBEEF, 32'd0, 32'hDEADBEEF, 32'd0, 32'd0, 32'd0, 1'b0);
    add("hold5",     IDLE, IDLE, 5'd5, 5'd5, 5'd1, 5'd0,
        32'hDEADBEEF, 32'hDEADBEEF, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    add("conf7",     gw(5'd7, 32'h1111), gw(5'd7, 32'h2222), 5'd7, 5'd7, 5'd7, 5'd5,
        32'h2222, 32'h2222, 32'h2222, 32'hDEADBEEF, 32'd0, 32'd0, 1'b0);
    add("post7",     IDLE, IDLE, 5'd7, 5'd5, 5'd0, 5'd7,
        32'h2222, 32'hDEADBEEF, 32'd0, 32'h2222, 32'd0, 32'd0, 1'b1);
    add("conf_clr",  IDLE, IDLE, 5'd7, 5'd7, 5'd7, 5'd7,
        32'h2222, 32'h2222, 32'h2222, 32'h2222, 32'd0, 32'd0, 1'b0);
    add("zero",      gw(5'd0, 32'hFFFFFFFF), gw(5'd0, 32'hFFFFFFFF), 5'd0, 5'd0, 5'd0, 5'd0,
        32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    add("zero_post", IDLE, IDLE, 5'd0, 5'd7, 5'd5, 5'd0,
        32'd0, 32'h2222, 32'hDEADBEEF, 32'd0, 32'd0, 32'd0, 1'b0);
    add("hilo",      slot(1'b1, 1'b0, 32'hA, 32'd0, 1'b0, 5'd0, 32'd0),
                     slot(1'b0, 1'b1, 32'd0, 32'hB, 1'b0, 5'd0, 32'd0),
        5'd5, 5'd7, 5'd0, 5'd1, 32'hDEADBEEF, 32'h2222, 32'd0, 32'd0, 32'hA, 32'hB, 1'b0);
    add("hilo_hold", IDLE, IDLE, 5'd5, 5'd7, 5'd0, 5'd1,
        32'hDEADBEEF, 32'h2222, 32'd0, 32'd0, 32'hA, 32'hB, 1'b0);
    add("hi_both",   slot(1'b1, 1'b0, 32'h1, 32'd0, 1'b0, 5'd0, 32'd0),
                     slot(1'b1, 1'b0, 32'h2, 32'd0, 1'b0, 5'd0, 32'd0),
        5'd5, 5'd7, 5'd0, 5'd1, 32'hDEADBEEF, 32'h2222, 32'd0, 32'd0, 32'h2, 32'hB, 1'b0);
    add("hi_post",   IDLE, IDLE, 5'd5, 5'd7, 5'd0, 5'd1,
        32'hDEADBEEF, 32'h2222, 32'd0, 32'd0, 32'h2, 32'hB, 1'b0);
    add("diff",      gw(5'd10, 32'hCAFEF00D), gw(5'd9, 32'h12345678), 5'd9, 5'd10, 5'd9, 5'd10,
        32'h12345678, 32'hCAFEF00D, 32'h12345678, 32'hCAFEF00D, 32'h2, 32'hB, 1'b0);
    add("diff_post", IDLE, IDLE, 5'd9, 5'd10, 5'd7, 5'd5,
        32'h12345678, 32'hCAFEF00D, 32'h2222, 32'hDEADBEEF, 32'h2, 32'hB, 1'b0);
    add("byp_old",   slot(1'b0, 1'b1, 32'd0, 32'hD, 1'b1, 5'd9, 32'hAAAA0000),
                     slot(1'b0, 1'b1, 32'd0, 32'hC, 1'b0, 5'd0, 32'd0),
        5'd9, 5'd10, 5'd9, 5'd0, 32'hAAAA0000, 32'hCAFEF00D, 32'hAAAA0000, 32'd0, 32'h2, 32'hC, 1'b0);
    add("byp_post",  IDLE, IDLE, 5'd9, 5'd10, 5'd5, 5'd7,
        32'hAAAA0000, 32'hCAFEF00D, 32'hDEADBEEF, 32'h2222, 32'h2, 32'hC, 1'b0);
    add("we_low",    slot(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 5'd9, 32'hBAD0BAD0),
                     slot(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 5'd9, 32'h12121212),
        5'd9, 5'd9, 5'd9, 5'd9, 32'hAAAA0000, 32'hAAAA0000, 32'hAAAA0000, 32'hAAAA0000, 32'h2, 32'hC, 1'b0);
    add("we_low_post", IDLE, IDLE, 5'd9, 5'd10, 5'd7, 5'd5,
        32'hAAAA0000, 32'hCAFEF00D, 32'h2222, 32'hDEADBEEF, 32'h2, 32'hC, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].s1, vecs[i].s2, vecs[i].ra1, vecs[i].ra2, vecs[i].ra3, vecs[i].ra4);
      #1;
      chk($sformatf("%s.rdata1", vecs[i].name), rf_if.rdata1, vecs[i].e1);
      chk($sformatf("%s.rdata2", vecs[i].name), rf_if.rdata2, vecs[i].e2);
      chk($sformatf("%s.rdata3", vecs[i].name), rf_if.rdata3, vecs[i].e3);
      chk($sformatf("%s.rdata4", vecs[i].name), rf_if.rdata4, vecs[i].e4);
      chk($sformatf("%s.hi", vecs[i].name), rf_if.hi_rdata, vecs[i].ehi);
      chk($sformatf("%s.lo", vecs[i].name), rf_if.lo_rdata, vecs[i].elo);
      chk($sformatf("%s.wr_conflict", vecs[i].name), {31'd0, rf_if.wr_conflict},
          {31'd0, vecs[i].econf});
    end

    // Async reset mid-stream: regs[3]=55, then pulse resetn between edges
    @(negedge clk);
    drive(gw(5'd3, 32'h55), IDLE, 5'd3, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    drive(IDLE, IDLE, 5'd3, 5'd9, 5'd0, 5'd0);
    #1;
    chk("areset.pre_r3", rf_if.rdata1, 32'h55);
    #1;
    resetn = 1'b0;
    #1;
    chk("areset.r3", rf_if.rdata1, 32'd0);
    chk("areset.r9", rf_if.rdata2, 32'd0);
    chk("areset.hi", rf_if.hi_rdata, 32'd0);
    chk("areset.lo", rf_if.lo_rdata, 32'd0);
    // A write presented during reset bypasses but is not stored
    drive(gw(5'd4, 32'h99), IDLE, 5'd3, 5'd4, 5'd0, 5'd0);
    #1;
    chk("areset.bypass_r4", rf_if.rdata2, 32'h99);
    @(negedge clk);
    drive(IDLE, IDLE, 5'd3, 5'd4, 5'd0, 5'd0);
    resetn = 1'b1;
    #1;
    chk("areset.lost_r4", rf_if.rdata2, 32'd0);
    chk("areset.post_r3", rf_if.rdata1, 32'd0);
    @(negedge clk);
    #1;
    chk("areset.hold_r4", rf_if.rdata2, 32'd0);
    chk("areset.wr_conflict", {31'd0, rf_if.wr_conflict}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
    $finish;
  end

endmodule
